// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: PC register, next-PC selection,
// instruction memory addressing and the IF/ID pipeline register.
module fetch_stage #(
  parameter int unsigned         PC_W     = 32,
  parameter logic [PC_W-1:0]     RESET_PC = '0,
  parameter int unsigned         CNT_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              branch_taken_i,
  input  logic [PC_W-1:0]   branch_target_i,
  input  logic              jump_i,
  input  logic [PC_W-1:0]   jump_target_i,
  output logic [PC_W-1:0]   imem_addr_o,
  input  logic [31:0]       imem_inst_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [31:0]       ifid_inst_o,
  output logic [PC_W-1:0]   ifid_pc_plus4_o,
  output logic              ifid_valid_o,
  output logic [CNT_W-1:0]  fetch_count_o
);

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic [PC_W-1:0]  pc_plus4_q, pc_plus4_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PC_W-1:0]  seq_pc;

  // Target low bits are dropped so the PC stays word aligned.
  logic unused_target_bits;
  assign unused_target_bits = ^{branch_target_i[1:0], jump_target_i[1:0]};

  assign seq_pc = pc_q + PC_W'(4);

  always_comb begin
    pc_d = seq_pc;
    if (branch_taken_i) begin
      pc_d = {branch_target_i[PC_W-1:2], 2'b00};
    end else if (jump_i) begin
      pc_d = {jump_target_i[PC_W-1:2], 2'b00};
    end else if (stall_i) begin
      pc_d = pc_q;
    end
  end

  // Flush wins over stall so a redirect under a load-use hazard still bubbles.
  always_comb begin
    inst_d     = imem_inst_i;
    pc_plus4_d = seq_pc;
    valid_d    = 1'b1;
    count_d    = count_q + CNT_W'(1);
    if (flush_i) begin
      inst_d     = '0;
      pc_plus4_d = '0;
      valid_d    = 1'b0;
      count_d    = count_q;
    end else if (stall_i) begin
      inst_d     = inst_q;
      pc_plus4_d = pc_plus4_q;
      valid_d    = valid_q;
      count_d    = count_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q       <= RESET_PC;
      inst_q     <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
    end
  end

  assign imem_addr_o     = pc_q;
  assign pc_o            = pc_q;
  assign ifid_inst_o     = inst_q;
  assign ifid_pc_plus4_o = pc_plus4_q;
  assign ifid_valid_o    = valid_q;
  assign fetch_count_o   = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a behavioural model pushes the expected
// post-edge state into a scoreboard each cycle; test tasks pop and compare it.
module tb_fetch_stage;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pp4;
    logic        valid;
    logic [31:0] cnt;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        br = 1'b0;
  logic [31:0] br_tgt = '0;
  logic        jmp = 1'b0;
  logic [31:0] jmp_tgt = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic [31:0] pc;
  logic [31:0] ifid_inst;
  logic [31:0] ifid_pp4;
  logic        ifid_valid;
  logic [31:0] fetch_count;

  int    tests_run = 0;
  int    tests_failed = 0;
  snap_t model = '0;
  snap_t sb[$];
  snap_t exp_s, obs_s;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0] + 16'h1234};
  endfunction

  assign imem_inst = mem_word(imem_addr);

  fetch_stage #(.PC_W(32), .RESET_PC(32'h0), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .branch_taken_i(br), .branch_target_i(br_tgt),
    .jump_i(jmp), .jump_target_i(jmp_tgt),
    .imem_addr_o(imem_addr), .imem_inst_i(imem_inst), .pc_o(pc),
    .ifid_inst_o(ifid_inst), .ifid_pc_plus4_o(ifid_pp4),
    .ifid_valid_o(ifid_valid), .fetch_count_o(fetch_count)
  );

  function automatic snap_t snap();
    snap_t s;
    s.addr  = imem_addr;
    s.pc    = pc;
    s.inst  = ifid_inst;
    s.pp4   = ifid_pp4;
    s.valid = ifid_valid;
    s.cnt   = fetch_count;
    return s;
  endfunction

  // Drive one cycle of inputs, predict the post-edge state, clock, settle.
  task automatic applyStimulus(input logic r, input logic s, input logic f,
                               input logic b, input logic [31:0] bt,
                               input logic j, input logic [31:0] jt);
    snap_t n;
    rst = r; stall = s; flush = f; br = b; br_tgt = bt; jmp = j; jmp_tgt = jt;
    n = model;
    if (r) begin
      n = '0;
    end else begin
      if (b)      n.pc = {bt[31:2], 2'b00};
      else if (j) n.pc = {jt[31:2], 2'b00};
      else if (s) n.pc = model.pc;
      else        n.pc = model.pc + 32'd4;
      if (f) begin
        n.inst = '0; n.pp4 = '0; n.valid = 1'b0;
      end else if (!s) begin
        n.inst  = mem_word(model.pc);
        n.pp4   = model.pc + 32'd4;
        n.valid = 1'b1;
        n.cnt   = model.cnt + 32'd1;
      end
    end
    n.addr = n.pc;
    model = n;
    sb.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    exp_s = sb.pop_front(); obs_s = snap(); tests_run++;
    if (obs_s !== exp_s) begin
      tests_failed++;
      $display("[TB] FAIL reset: got pc=%h inst=%h pp4=%h v=%b cnt=%0d want pc=%h inst=%h pp4=%h v=%b cnt=%0d",
               obs_s.pc, obs_s.inst, obs_s.pp4, obs_s.valid, obs_s.cnt, exp_s.pc, exp_s.inst, exp_s.pp4, exp_s.valid, exp_s.cnt);
    end
    tests_run++;
    if (pc !== 32'h0 || ifid_valid !== 1'b0 || fetch_count !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_const: got pc=%h v=%b cnt=%0d want pc=0 v=0 cnt=0", pc, ifid_valid, fetch_count);
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      exp_s = sb.pop_front(); obs_s = snap(); tests_run++;
      if (obs_s !== exp_s) begin
        tests_failed++;
        $display("[TB] FAIL seq[%0d]: got pc=%h inst=%h pp4=%h v=%b cnt=%0d want pc=%h inst=%h pp4=%h v=%b cnt=%0d", i,
                 obs_s.pc, obs_s.inst, obs_s.pp4, obs_s.valid, obs_s.cnt, exp_s.pc, exp_s.inst, exp_s.pp4, exp_s.valid, exp_s.cnt);
      end
    end
    tests_run++;
    if (imem_addr !== 32'hC || ifid_inst !== mem_word(32'h8) || ifid_pp4 !== 32'hC || fetch_count !== 32'd3) begin
      tests_failed++;
      $display("[TB] FAIL seq_const: got addr=%h inst=%h pp4=%h cnt=%0d want addr=c inst=%h pp4=c cnt=3",
               imem_addr, ifid_inst, ifid_pp4, fetch_count, mem_word(32'h8));
    end
  endtask

  task automatic test_stall();
    logic [3:0] st_pat = 4'b0011;
    test_reset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    void'(sb.pop_front()); void'(sb.pop_front());
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, st_pat[i], 0, 0, 0, 0, 0);
      exp_s = sb.pop_front(); obs_s = snap(); tests_run++;
      if (obs_s !== exp_s) begin
        tests_failed++;
        $display("[TB] FAIL stall[%0d]: got pc=%h inst=%h v=%b cnt=%0d want pc=%h inst=%h v=%b cnt=%0d", i,
                 obs_s.pc, obs_s.inst, obs_s.valid, obs_s.cnt, exp_s.pc, exp_s.inst, exp_s.valid, exp_s.cnt);
      end
      if (i == 1) begin
        tests_run++;
        if (pc !== 32'h8 || ifid_inst !== mem_word(32'h4) || fetch_count !== 32'd2) begin
          tests_failed++;
          $display("[TB] FAIL stall_hold: got pc=%h inst=%h cnt=%0d want pc=8 inst=%h cnt=2", pc, ifid_inst, fetch_count, mem_word(32'h4));
        end
      end
    end
    tests_run++;
    if (pc !== 32'hC || ifid_inst !== mem_word(32'h8)) begin
      tests_failed++;
      $display("[TB] FAIL stall_release: got pc=%h inst=%h want pc=c inst=%h", pc, ifid_inst, mem_word(32'h8));
    end
  endtask

  task automatic test_branch_flush();
    applyStimulus(0, 0, 1, 0, 0, 1, 32'h10);
    applyStimulus(0, 0, 1, 1, 32'h23, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      exp_s = sb.pop_front(); tests_run++;
      if (i == 2) obs_s = snap();
      else obs_s = exp_s;
      if (i == 2 && obs_s !== exp_s) begin
        tests_failed++;
        $display("[TB] FAIL branch_follow: got pc=%h inst=%h v=%b want pc=%h inst=%h v=%b",
                 obs_s.pc, obs_s.inst, obs_s.valid, exp_s.pc, exp_s.inst, exp_s.valid);
      end else if (i != 2) begin
        tests_run--;
      end
    end
    tests_run++;
    if (ifid_inst !== mem_word(32'h20) || pc !== 32'h24 || ifid_pp4 !== 32'h24 || ifid_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL branch_const: got pc=%h inst=%h pp4=%h v=%b want pc=24 inst=%h pp4=24 v=1",
               pc, ifid_inst, ifid_pp4, ifid_valid, mem_word(32'h20));
    end
  endtask

  task automatic test_bubble();
    applyStimulus(0, 0, 1, 1, 32'h23, 0, 0);
    exp_s = sb.pop_front(); obs_s = snap(); tests_run++;
    if (obs_s !== exp_s || pc !== 32'h20 || ifid_valid !== 1'b0 || ifid_inst !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL branch_bubble: got pc=%h inst=%h v=%b want pc=20 inst=0 v=0", pc, ifid_inst, ifid_valid);
    end
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    exp_s = sb.pop_front(); obs_s = snap(); tests_run++;
    if (obs_s !== exp_s) begin
      tests_failed++;
      $display("[TB] FAIL stall_flush: got pc=%h v=%b cnt=%0d want pc=%h v=%b cnt=%0d",
               obs_s.pc, obs_s.valid, obs_s.cnt, exp_s.pc, exp_s.valid, exp_s.cnt);
    end
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    exp_s = sb.pop_front(); obs_s = snap(); tests_run++;
    if (obs_s !== exp_s) begin
      tests_failed++;
      $display("[TB] FAIL flush_only: got pc=%h v=%b cnt=%0d want pc=%h v=%b cnt=%0d",
               obs_s.pc, obs_s.valid, obs_s.cnt, exp_s.pc, exp_s.valid, exp_s.cnt);
    end
    applyStimulus(0, 1, 1, 1, 32'h60, 0, 0);
    exp_s = sb.pop_front(); obs_s = snap(); tests_run++;
    if (obs_s !== exp_s || pc !== 32'h60) begin
      tests_failed++;
      $display("[TB] FAIL stall_branch_flush: got pc=%h v=%b want pc=60 v=0", obs_s.pc, obs_s.valid);
    end
  endtask

  task automatic test_priority();
    applyStimulus(0, 0, 0, 1, 32'h40, 1, 32'h80);
    exp_s = sb.pop_front(); obs_s = snap(); tests_run++;
    if (obs_s !== exp_s || pc !== 32'h40) begin
      tests_failed++;
      $display("[TB] FAIL branch_over_jump: got pc=%h cnt=%0d want pc=40 cnt=%0d", obs_s.pc, obs_s.cnt, exp_s.cnt);
    end
    applyStimulus(0, 1, 0, 0, 0, 1, 32'h80);
    exp_s = sb.pop_front(); obs_s = snap(); tests_run++;
    if (obs_s !== exp_s || pc !== 32'h80) begin
      tests_failed++;
      $display("[TB] FAIL jump_over_stall: got pc=%h inst=%h want pc=80 inst=%h", obs_s.pc, obs_s.inst, exp_s.inst);
    end
  endtask

  task automatic test_wrap();
    applyStimulus(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
    exp_s = sb.pop_front(); obs_s = snap(); tests_run++;
    if (obs_s !== exp_s || pc !== 32'hFFFF_FFFC) begin
      tests_failed++;
      $display("[TB] FAIL jump_align: got pc=%h want pc=fffffffc", obs_s.pc);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    exp_s = sb.pop_front(); obs_s = snap(); tests_run++;
    if (obs_s !== exp_s || pc !== 32'h0 || ifid_pp4 !== 32'h0 || $isunknown(obs_s)) begin
      tests_failed++;
      $display("[TB] FAIL wrap: got pc=%h pp4=%h inst=%h want pc=0 pp4=0 inst=%h", obs_s.pc, obs_s.pp4, obs_s.inst, exp_s.inst);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 5) == 0), $urandom,
                    ($urandom_range(0, 5) == 0), $urandom);
      exp_s = sb.pop_front(); obs_s = snap(); tests_run++;
      if (obs_s !== exp_s) begin
        tests_failed++;
        $display("[TB] FAIL random[%0d]: got pc=%h inst=%h pp4=%h v=%b cnt=%0d want pc=%h inst=%h pp4=%h v=%b cnt=%0d", i,
                 obs_s.pc, obs_s.inst, obs_s.pp4, obs_s.valid, obs_s.cnt, exp_s.pc, exp_s.inst, exp_s.pp4, exp_s.valid, exp_s.cnt);
      end
    end
  endtask

  task automatic test_mid_reset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    void'(sb.pop_front());
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    exp_s = sb.pop_front(); obs_s = snap(); tests_run++;
    if (obs_s !== exp_s || ifid_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset: got v=%b cnt=%0d want v=1 cnt=%0d", obs_s.valid, obs_s.cnt, exp_s.cnt);
    end
    applyStimulus(1, 1, 1, 1, 32'h100, 1, 32'h200);
    exp_s = sb.pop_front(); obs_s = snap(); tests_run++;
    if (obs_s !== exp_s || pc !== 32'h0 || ifid_valid !== 1'b0 || fetch_count !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset: got pc=%h v=%b cnt=%0d want pc=0 v=0 cnt=0", obs_s.pc, obs_s.valid, obs_s.cnt);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_flush();
    test_bubble();
    test_priority();
    test_wrap();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
